// File: rtl/mc_controller_pl.sv
// Multicycle ARM-subset controller: main FSM, registered flags/condition, multiply wait and FPU handshake.
// Optional FPU timeout watchdog enabled by defining MC_FPU_TIMEOUT_EN.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | after reset, all outputs low
// FETCH    | IR load, PC <- PC+4
// DECODE   | register read, condition latched
// MEMADR   | address = base + offset
// MEMRD    | data memory read
// MEMWB    | load result to register file
// MEMWR    | data memory write
// EXECR    | ALU op, register operand
// EXECI    | ALU op, immediate operand
// ALUWB    | ALU result to register file (and PC when Rd=15)
// MULWAIT  | multiplier latency, shared counter runs
// LMULWB1  | long multiply low word write
// LMULWB2  | long multiply high word write
// BRANCH   | branch target to PC
// FPUWAIT  | FPU start pulse, wait for done (or timeout)
module mc_controller_pl #(
  parameter int MUL_LAT = 3,
  parameter int FPU_TO  = 15,
  parameter int CNT_W   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:4] Instr,
  input  logic [3:0]  ALUFlags,
  input  logic        FPUDone,
  output logic        FPUStart,
  output logic        PCWrite,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic        IRWrite,
  output logic        FPUWrite,
  output logic        AdrSrc,
  output logic [1:0]  RegSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ImmSrc,
  output logic [2:0]  ALUControl,
  output logic        longFlag,
  output logic        FPUErr
);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXECR,
    S_EXECI, S_ALUWB, S_MULWAIT, S_LMULWB1, S_LMULWB2, S_BRANCH, S_FPUWAIT
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;
  localparam logic [2:0] ALU_MUL = 3'b100;
  localparam logic [2:0] ALU_EOR = 3'b101;

  // Counter only ever needs to reach the larger terminal count; saturating there
  // keeps cnt==0 meaning "first cycle in state" for arbitrarily long FPU waits.
  localparam int CNT_MAX = (MUL_LAT > FPU_TO) ? MUL_LAT : FPU_TO;
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_LAT - 1);

  state_t state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [3:0] flags_q;
  logic condex_q, cond_ok, cv_upd, is_mul, is_long;
  logic [2:0] alu_dp;

  logic [3:0] cond, rd, mulf;
  logic [1:0] op;
  logic [5:0] funct;
  logic unused_instr;

  assign cond  = Instr[31:28];
  assign op    = Instr[27:26];
  assign funct = Instr[25:20];
  assign rd    = Instr[15:12];
  assign mulf  = Instr[7:4];
  assign unused_instr = ^{Instr[19:16], Instr[11:8]};

  assign is_mul  = (op == 2'b00) && !funct[5] && (mulf == 4'b1001);
  assign is_long = is_mul && funct[3];

  always_comb begin
    unique case (funct[4:1])
      4'b0100, 4'b1011: alu_dp = ALU_ADD;
      4'b0010, 4'b1010: alu_dp = ALU_SUB;
      4'b0000, 4'b1000: alu_dp = ALU_AND;
      4'b1100:          alu_dp = ALU_ORR;
      4'b0001, 4'b1001: alu_dp = ALU_EOR;
      default:          alu_dp = ALU_ADD;
    endcase
  end

  assign cv_upd = (alu_dp == ALU_ADD) || (alu_dp == ALU_SUB);

  // flags_q = {N,Z,C,V}
  always_comb begin
    unique case (cond)
      4'b0000: cond_ok = flags_q[2];
      4'b0001: cond_ok = !flags_q[2];
      4'b0010: cond_ok = flags_q[1];
      4'b0011: cond_ok = !flags_q[1];
      4'b0100: cond_ok = flags_q[3];
      4'b0101: cond_ok = !flags_q[3];
      4'b0110: cond_ok = flags_q[0];
      4'b0111: cond_ok = !flags_q[0];
      4'b1000: cond_ok = flags_q[1] && !flags_q[2];
      4'b1001: cond_ok = !flags_q[1] || flags_q[2];
      4'b1010: cond_ok = (flags_q[3] == flags_q[0]);
      4'b1011: cond_ok = (flags_q[3] != flags_q[0]);
      4'b1100: cond_ok = !flags_q[2] && (flags_q[3] == flags_q[0]);
      4'b1101: cond_ok = flags_q[2] || (flags_q[3] != flags_q[0]);
      4'b1110: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end

`ifdef MC_FPU_TIMEOUT_EN
  localparam logic [CNT_W-1:0] FPU_LAST = CNT_W'(FPU_TO - 1);
  logic fpu_timeout;
  assign fpu_timeout = (state == S_FPUWAIT) && condex_q && !FPUDone && (cnt == FPU_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)           FPUErr <= 1'b0;
    else if (fpu_timeout) FPUErr <= 1'b1;
  end
`else
  assign FPUErr = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      flags_q  <= 4'b0000;
      condex_q <= 1'b0;
    end else begin
      state <= state_n;
      if (state_n != state)  cnt <= '0;
      else if (cnt != CNT_SAT) cnt <= cnt + 1'b1;
      if (state == S_DECODE) condex_q <= cond_ok;
      if ((state == S_EXECR || state == S_EXECI) && funct[0] && condex_q)
        flags_q <= {ALUFlags[3:2], cv_upd ? ALUFlags[1:0] : flags_q[1:0]};
    end
  end

  always_comb begin
    state_n    = state;
    FPUStart   = 1'b0;
    PCWrite    = 1'b0;
    MemWrite   = 1'b0;
    RegWrite   = 1'b0;
    IRWrite    = 1'b0;
    FPUWrite   = 1'b0;
    AdrSrc     = 1'b0;
    RegSrc     = {(op == 2'b01) && !funct[0], op == 2'b10};
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    ImmSrc     = op;
    ALUControl = ALU_ADD;
    longFlag   = 1'b0;
    case (state)
      S_IDLE: begin
        RegSrc  = 2'b00;
        ImmSrc  = 2'b00;
        state_n = S_FETCH;
      end
      S_FETCH: begin
        IRWrite   = 1'b1;
        PCWrite   = 1'b1;
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        state_n   = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        unique case (op)
          2'b00: state_n = is_mul ? S_MULWAIT : (funct[5] ? S_EXECI : S_EXECR);
          2'b01: state_n = S_MEMADR;
          2'b10: state_n = S_BRANCH;
          default: state_n = S_FPUWAIT;
        endcase
      end
      S_MEMADR: begin
        ALUSrcB = 2'b01;
        state_n = funct[0] ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        AdrSrc  = 1'b1;
        state_n = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = condex_q;
        state_n   = S_FETCH;
      end
      S_MEMWR: begin
        AdrSrc   = 1'b1;
        MemWrite = condex_q;
        state_n  = S_FETCH;
      end
      S_EXECR: begin
        ALUControl = alu_dp;
        state_n    = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcB    = 2'b01;
        ALUControl = alu_dp;
        state_n    = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite = condex_q && (funct[4:3] != 2'b10);
        PCWrite  = condex_q && (rd == 4'd15);
        state_n  = S_FETCH;
      end
      S_MULWAIT: begin
        ALUControl = ALU_MUL;
        if (cnt == MUL_LAST) state_n = is_long ? S_LMULWB1 : S_ALUWB;
      end
      S_LMULWB1: begin
        RegWrite = condex_q;
        state_n  = S_LMULWB2;
      end
      S_LMULWB2: begin
        RegWrite = condex_q;
        longFlag = 1'b1;
        state_n  = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        PCWrite   = condex_q;
        state_n   = S_FETCH;
      end
      S_FPUWAIT: begin
        if (!condex_q) begin
          state_n = S_FETCH;
        end else begin
          FPUStart = (cnt == '0);
          if (FPUDone) begin
            FPUWrite = 1'b1;
            state_n  = S_FETCH;
          end
`ifdef MC_FPU_TIMEOUT_EN
          else if (fpu_timeout) state_n = S_FETCH;
`endif
        end
      end
      default: begin
        RegSrc  = 2'b00;
        ImmSrc  = 2'b00;
        state_n = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mc_controller_pl.sv
// Scoreboard bench for mc_controller_pl: per-cycle expected control vectors queued per instruction.
module tb_mc_controller_pl;

  localparam int MUL_LAT = 3;
  localparam int FPU_TO  = 15;

  logic clk = 1'b0;
  logic reset;
  logic [31:4] Instr;
  logic [3:0]  ALUFlags;
  logic FPUDone;
  logic FPUStart, PCWrite, MemWrite, RegWrite, IRWrite, FPUWrite, AdrSrc;
  logic [1:0] RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
  logic [2:0] ALUControl;
  logic longFlag, FPUErr;

  mc_controller_pl #(.MUL_LAT(MUL_LAT), .FPU_TO(FPU_TO), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags), .FPUDone(FPUDone),
    .FPUStart(FPUStart), .PCWrite(PCWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
    .IRWrite(IRWrite), .FPUWrite(FPUWrite), .AdrSrc(AdrSrc), .RegSrc(RegSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc),
    .ALUControl(ALUControl), .longFlag(longFlag), .FPUErr(FPUErr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic fst, pcw, memw, regw, irw, fpw, adr;
    logic [1:0] regsrc, srca, srcb, res, imm;
    logic [2:0] aluc;
    logic lng, err;
  } ctl_t;

  ctl_t obs;
  assign obs = {FPUStart, PCWrite, MemWrite, RegWrite, IRWrite, FPUWrite, AdrSrc,
                RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl, longFlag, FPUErr};

  ctl_t  expq[$];
  string tagq[$];
  int total = 0;
  int bad = 0;
  logic err_exp = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic ctl_t base(input logic [31:0] ins);
    ctl_t c;
    c = '0;
    c.imm    = ins[27:26];
    c.regsrc = {(ins[27:26] == 2'b01) && !ins[20], ins[27:26] == 2'b10};
    c.err    = err_exp;
    return c;
  endfunction

  task automatic push(input string tag, input ctl_t c);
    expq.push_back(c);
    tagq.push_back(tag);
  endtask

  task automatic exp_fd(input string nm, input logic [31:0] ins);
    ctl_t c;
    c = base(ins);
    c.irw = 1'b1; c.pcw = 1'b1; c.srca = 2'b01; c.srcb = 2'b10; c.res = 2'b10;
    push({nm, ".fetch"}, c);
    c = base(ins);
    c.srca = 2'b01; c.srcb = 2'b10; c.res = 2'b10;
    push({nm, ".decode"}, c);
  endtask

  // Drives one instruction and pops one expected vector per cycle; starts in FETCH.
  task automatic run(input logic [31:0] ins, input logic [3:0] fl, input int done_at);
    int n;
    ctl_t e;
    string t;
    Instr    = ins[31:4];
    ALUFlags = fl;
    n = expq.size();
    for (int i = 0; i < n; i++) begin
      FPUDone = (i == done_at);
      @(negedge clk);
      e = expq.pop_front();
      t = tagq.pop_front();
      chk(t, 32'(obs), 32'(e));
      @(posedge clk); #1;
    end
    FPUDone = 1'b0;
  endtask

  task automatic dp(input string nm, input logic [31:0] ins, input logic [2:0] aluc,
                    input logic [3:0] fl, input logic rw, input logic pw);
    ctl_t c;
    exp_fd(nm, ins);
    c = base(ins);
    c.srcb = ins[25] ? 2'b01 : 2'b00;
    c.aluc = aluc;
    push({nm, ".exec"}, c);
    c = base(ins);
    c.regw = rw; c.pcw = pw;
    push({nm, ".aluwb"}, c);
    run(ins, fl, -1);
  endtask

  task automatic br(input string nm, input logic [3:0] cnd, input logic taken);
    logic [31:0] ins;
    ctl_t c;
    ins = {cnd, 28'hA000000};
    exp_fd(nm, ins);
    c = base(ins);
    c.srcb = 2'b01; c.res = 2'b10; c.pcw = taken;
    push({nm, ".branch"}, c);
    run(ins, 4'b0000, -1);
  endtask

  task automatic mul(input string nm, input logic [31:0] ins, input logic lng);
    ctl_t c;
    exp_fd(nm, ins);
    for (int k = 0; k < MUL_LAT; k++) begin
      c = base(ins);
      c.aluc = 3'b100;
      push($sformatf("%s.mulwait%0d", nm, k), c);
    end
    c = base(ins);
    c.regw = 1'b1;
    if (lng) begin
      push({nm, ".lmulwb1"}, c);
      c.lng = 1'b1;
      push({nm, ".lmulwb2"}, c);
    end else begin
      push({nm, ".aluwb"}, c);
    end
    run(ins, 4'b0000, -1);
  endtask

  task automatic mem(input string nm, input logic [31:0] ins, input logic ce);
    ctl_t c;
    exp_fd(nm, ins);
    c = base(ins);
    c.srcb = 2'b01;
    push({nm, ".memadr"}, c);
    c = base(ins);
    c.adr = 1'b1;
    if (ins[20]) begin
      push({nm, ".memrd"}, c);
      c = base(ins);
      c.res = 2'b01; c.regw = ce;
      push({nm, ".memwb"}, c);
    end else begin
      c.memw = ce;
      push({nm, ".memwr"}, c);
    end
    run(ins, 4'b0000, -1);
  endtask

  // nwait FPUWAIT cycles; done_wait = FPUWAIT cycle index carrying FPUDone (-1 = none).
  task automatic fpu(input string nm, input logic [31:0] ins, input logic ce,
                     input int nwait, input int done_wait);
    ctl_t c;
    exp_fd(nm, ins);
    for (int k = 0; k < nwait; k++) begin
      c = base(ins);
      c.fst = ce && (k == 0);
      c.fpw = (k == done_wait);
      push($sformatf("%s.fpuwait%0d", nm, k), c);
    end
    run(ins, 4'b0000, (done_wait < 0) ? -1 : 2 + done_wait);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; Instr = '0; ALUFlags = 4'b0000; FPUDone = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); chk("por", 32'(obs), 32'd0);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk); chk("por.idle", 32'(obs), 32'd0);
    @(posedge clk); #1;

    // MUL interrupted by reset in its second MULWAIT cycle
    begin
      ctl_t c;
      exp_fd("mulrst", 32'hE0010392);
      c = base(32'hE0010392); c.aluc = 3'b100;
      push("mulrst.mulwait0", c);
      run(32'hE0010392, 4'b0000, -1);
      reset = 1'b0;
      @(negedge clk); chk("rst.mid", 32'(obs), 32'd0);
      @(posedge clk); #1 reset = 1'b1;
      @(negedge clk); chk("rst.idle", 32'(obs), 32'd0);
      @(posedge clk); #1;
    end

    dp("adds", 32'hE0921003, 3'b000, 4'b0100, 1'b1, 1'b0);   // Z=1
    br("beq1", 4'b0000, 1'b1);
    br("bne1", 4'b0001, 1'b0);
    dp("subs", 32'hE0521003, 3'b001, 4'b0010, 1'b1, 1'b0);   // Z=0 C=1
    dp("ands", 32'hE0121003, 3'b010, 4'b1001, 1'b1, 1'b0);   // N=1, C/V kept
    br("bcs", 4'b0010, 1'b1);
    br("bmi", 4'b0100, 1'b1);
    br("bvs", 4'b0110, 1'b0);
    br("beq2", 4'b0000, 1'b0);
    dp("orri", 32'hE3821001, 3'b011, 4'b1111, 1'b1, 1'b0);   // S=0, flags untouched
    br("bpl", 4'b0101, 1'b0);
    dp("cmp", 32'hE1520003, 3'b001, 4'b0110, 1'b0, 1'b0);    // Z=1 C=1, no write
    br("beq3", 4'b0000, 1'b1);
    br("bhi", 4'b1000, 1'b0);
    mul("mul", 32'hE0010392, 1'b0);
    mul("umull", 32'hE0810392, 1'b1);
    mem("ldr", 32'hE5921004, 1'b1);
    mem("strnv", 32'hF5821004, 1'b0);
    mem("stral", 32'hE5821004, 1'b1);
    fpu("fpu0", 32'hEC000000, 1'b1, 1, 0);
    fpu("fpu3", 32'hEC000000, 1'b1, 4, 3);
    fpu("fpunv", 32'hFC000000, 1'b0, 1, -1);
`ifdef MC_FPU_TIMEOUT_EN
    fpu("fputo", 32'hEC000000, 1'b1, FPU_TO, -1);
    err_exp = 1'b1;
`else
    fpu("fpulong", 32'hEC000000, 1'b1, 21, 20);
`endif
    dp("addpc", 32'hE082F003, 3'b000, 4'b0000, 1'b1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mc_controller_pl.md
Name: mc_controller_pl

Overview:
- Parametrised successor to the multicycle ARM-subset controller: explicit main FSM, registered condition logic and flags.
- Adds variable-latency multiply wait, two-cycle long-multiply writeback and an FPU start/done handshake.
- Sits between the instruction register and the multicycle datapath; drives every datapath enable and mux select.

Parameters:
MUL_LAT, 3, cycles spent in MULWAIT before writeback (1..15)
FPU_TO, 15, FPU timeout in cycles (used only with the optional feature)
CNT_W, 4, width of the shared wait counter; must hold max(MUL_LAT, FPU_TO)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
Instr  in  28  instruction bits [31:4]
ALUFlags  in  4  {N,Z,C,V} from ALU
FPUDone  in  1  FPU result valid (single-cycle pulse)
FPUStart  out  1  FPU start pulse
PCWrite  out  1  PC write enable
MemWrite  out  1  memory write enable
RegWrite  out  1  register file write enable
IRWrite  out  1  instruction register write enable
FPUWrite  out  1  FPU result writeback enable
AdrSrc  out  1  0=PC, 1=ALU result
RegSrc  out  2  register-address selects
ALUSrcA  out  2  ALU A select
ALUSrcB  out  2  ALU B select
ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALU direct
ImmSrc  out  2  immediate extend select
ALUControl  out  3  000 ADD, 001 SUB, 010 AND, 011 ORR, 100 MUL, 101 EOR
longFlag  out  1  high-word cycle of a long multiply
FPUErr  out  1  sticky FPU timeout flag

Behaviour:
- Reset low, asynchronous: state=IDLE, flags=0, CondEx_q=0, counter=0, FPUErr=0.
- In IDLE all outputs are 0. After reset release, IDLE->FETCH on the next edge.
- Decode by Op=Instr[27:26]:
  - 00 data-processing; multiply when Funct[5]=0 and Mul=1001; long multiply when Funct[3]=1.
  - 01 memory.
  - 10 branch.
  - 11 FPU.
- FETCH: IRWrite=1, AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ALUControl=ADD, ResultSrc=10, PCWrite=1 (unconditional). -> DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10. Latch CondEx_q from Cond vs registered flags (ARM EQ..AL; 1111 = never). Transitions:
  - memory -> MEMADR
  - reg data-processing -> EXECR
  - immediate (Funct[5]=1) -> EXECI
  - multiply -> MULWAIT
  - branch -> BRANCH
  - FPU -> FPUWAIT
- MEMADR: ALUSrcA=00, ALUSrcB=01, ADD. Load (Funct[0]=1) -> MEMRD; store -> MEMWR.
- MEMRD: AdrSrc=1 -> MEMWB. MEMWB: ResultSrc=01, RegWrite=CondEx_q -> FETCH.
- MEMWR: AdrSrc=1, MemWrite=CondEx_q -> FETCH.
- EXECR / EXECI: ALUSrcB=00 / 01, ALUControl from Funct[4:1] -> ALUWB.
- Flag update on the execute edge when Funct[0]=1 and CondEx_q: NZ always; CV only for ADD/SUB.
- ALUWB: ResultSrc=00. RegWrite=CondEx_q, except CMP-class (Funct[4:3]=10) gives RegWrite=0. Rd=15 also asserts PCWrite=CondEx_q -> FETCH.
- MULWAIT: ALUControl=MUL. Counter increments from 0; at MUL_LAT-1 -> ALUWB (short) or LMULWB1 (long). MUL_LAT=1 gives exactly one MULWAIT cycle.
- LMULWB1: RegWrite=CondEx_q, longFlag=0 -> LMULWB2. LMULWB2: RegWrite=CondEx_q, longFlag=1 -> FETCH.
- BRANCH: ALUSrcA=00, ALUSrcB=01, ResultSrc=10, PCWrite=CondEx_q -> FETCH.
- FPUWAIT:
  - FPUStart=1 on the first cycle only, and only if CondEx_q; CondEx_q=0 -> FETCH immediately.
  - On FPUDone: FPUWrite=1 that cycle -> FETCH.
  - FPUDone arriving on the same cycle as FPUStart is accepted.
- ImmSrc = Op; RegSrc = {Op==01 store, Op==10}.
- Counter clears on every state entry.
- Illegal state encoding -> IDLE.

Optional Feature:
- MC_FPU_TIMEOUT_EN defined:
  - FPUWAIT counts cycles; at FPU_TO without FPUDone, set FPUErr and go to FETCH with no writeback.
  - FPUErr clears only on reset.
- MC_FPU_TIMEOUT_EN undefined: FPUWAIT waits indefinitely and FPUErr is tied 0.

Test Plan:
- Reset low mid-MULWAIT, release -> all outputs 0 for one cycle, then FETCH with IRWrite=1, PCWrite=1.
- ADDS R1,R2,R3 with result 0 -> RegWrite=1 in ALUWB, Z=1 registered; a following BEQ gives PCWrite=1 in BRANCH.
- BNE with Z=1 -> BRANCH has PCWrite=0; FETCH entered next cycle.
- MUL with MUL_LAT=3 -> exactly 3 MULWAIT cycles then ALUWB. UMULL -> RegWrite in two consecutive cycles, longFlag=0 then 1.
- LDR -> MEMADR, MEMRD, MEMWB (ResultSrc=01, RegWrite=1), 5 cycles total. STR with Cond false -> MemWrite stays 0.
- FPU op with FPUDone held 0 and MC_FPU_TIMEOUT_EN, FPU_TO=15 -> FPUStart one cycle, FPUErr=1 after 15 cycles, FPUWrite never asserted.
